// File: rtl/simon_pkg.sv
// Shared types and defaults for the SIMON 64/96 job sequencer.
package simon_pkg;

  localparam int unsigned SIMON_N = 32;
  localparam int unsigned SIMON_M = 3;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    KEY_REQ   = 3'd1,
    KEY_WAIT  = 3'd2,
    DATA_REQ  = 3'd3,
    DATA_WAIT = 3'd4,
    READ      = 3'd5,
    OUT       = 3'd6
  } state_e;

  typedef logic [SIMON_M-1:0][SIMON_N-1:0] key_t;
  typedef logic [2*SIMON_N-1:0]            block_t;

  // States in which the sequencer is waiting on the core and the watchdog runs.
  function automatic logic is_core_wait(input state_e s);
    return (s == KEY_REQ) || (s == KEY_WAIT) || (s == DATA_REQ) ||
           (s == DATA_WAIT) || (s == READ);
  endfunction

endpackage

// File: rtl/simon_wdog.sv
// Stall watchdog: counts cycles spent in one core-wait state, flags when TIMEOUT is hit.
module simon_wdog #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic nR,
  input  logic clr,
  input  logic en,
  output logic timeout_c
);

  localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // The TIMEOUT-th cycle in a state is the one that aborts.
  assign timeout_c = en && (cnt_q == LIMIT);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !timeout_c) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge nR) begin
    if (!nR) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/simon_job_ctrl.sv
// Valid/ready job front-end for one SIMON core: key caching, core handshakes,
// result channel and watchdog abort.
module simon_job_ctrl
  import simon_pkg::*;
#(
  parameter int unsigned N       = SIMON_N,
  parameter int unsigned M       = SIMON_M,
  parameter int unsigned TAGW    = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              nR,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_enc_dec,
  input  logic [2*N-1:0]    req_data,
  input  logic [M*N-1:0]    req_key,
  input  logic [TAGW-1:0]   req_tag,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [2*N-1:0]    res_data,
  output logic [TAGW-1:0]   res_tag,
  output logic              res_err,
  output logic              core_newKey,
  output logic              core_newData,
  output logic              core_readData,
  output logic              core_enc_dec,
  output logic [M*N-1:0]    core_key,
  output logic [2*N-1:0]    core_plain,
  input  logic              core_ldKey,
  input  logic              core_ldData,
  input  logic              core_doneKey,
  input  logic              core_doneData,
  input  logic [2*N-1:0]    core_cipher
);

  state_e            state_q, state_d;
  logic              req_ready_q, req_ready_d;
  logic              res_valid_q, res_valid_d;
  logic [2*N-1:0]    res_data_q, res_data_d;
  logic [TAGW-1:0]   res_tag_q, res_tag_d;
  logic              res_err_q, res_err_d;
  logic              new_key_q, new_key_d;
  logic              new_data_q, new_data_d;
  logic              read_data_q, read_data_d;
  logic              enc_dec_q, enc_dec_d;
  logic [M*N-1:0]    key_q, key_d;
  logic [2*N-1:0]    plain_q, plain_d;
  logic              key_valid_q, key_valid_d;
  logic              accept_c;
  logic              key_miss_c;
  logic              wd_clr_c;
  logic              wd_en_c;
  logic              timeout_c;

  assign accept_c   = (state_q == IDLE) && req_valid && req_ready_q;
  // key_q doubles as the cache of the last key handed to the core.
  assign key_miss_c = !key_valid_q || (req_key != key_q);
  assign wd_clr_c   = (state_d != state_q);
  assign wd_en_c    = is_core_wait(state_q);

  simon_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk       (clk),
    .nR        (nR),
    .clr       (wd_clr_c),
    .en        (wd_en_c),
    .timeout_c (timeout_c)
  );

  always_comb begin
    state_d     = state_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_tag_d   = res_tag_q;
    res_err_d   = res_err_q;
    new_key_d   = new_key_q;
    new_data_d  = new_data_q;
    read_data_d = read_data_q;
    enc_dec_d   = enc_dec_q;
    key_d       = key_q;
    plain_d     = plain_q;
    key_valid_d = key_valid_q;
    req_ready_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept_c) begin
          enc_dec_d = req_enc_dec;
          plain_d   = req_data;
          res_tag_d = req_tag;
          res_err_d = 1'b0;
          if (key_miss_c) begin
            key_d     = req_key;
            new_key_d = 1'b1;
            state_d   = KEY_REQ;
          end else begin
            new_data_d = 1'b1;
            state_d    = DATA_REQ;
          end
        end
      end
      KEY_REQ: begin
        if (core_ldKey) begin
          new_key_d = 1'b0;
          if (core_doneKey) begin
            key_valid_d = 1'b1;
            new_data_d  = 1'b1;
            state_d     = DATA_REQ;
          end else begin
            state_d = KEY_WAIT;
          end
        end
      end
      KEY_WAIT: begin
        if (core_doneKey) begin
          key_valid_d = 1'b1;
          new_data_d  = 1'b1;
          state_d     = DATA_REQ;
        end
      end
      DATA_REQ: begin
        if (core_ldData) begin
          new_data_d = 1'b0;
          if (core_doneData) begin
            res_data_d  = core_cipher;
            read_data_d = 1'b1;
            state_d     = READ;
          end else begin
            state_d = DATA_WAIT;
          end
        end
      end
      DATA_WAIT: begin
        if (core_doneData) begin
          res_data_d  = core_cipher;
          read_data_d = 1'b1;
          state_d     = READ;
        end
      end
      READ: begin
        if (!core_doneData) begin
          read_data_d = 1'b0;
          res_valid_d = 1'b1;
          state_d     = OUT;
        end
      end
      OUT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A stalled core handshake returns an error result instead of hanging.
    if (timeout_c) begin
      new_key_d   = 1'b0;
      new_data_d  = 1'b0;
      read_data_d = 1'b0;
      key_valid_d = 1'b0;
      res_data_d  = '0;
      res_err_d   = 1'b1;
      res_valid_d = 1'b1;
      state_d     = OUT;
    end

    req_ready_d = (state_d == IDLE) && !res_valid_d;
  end

  always_ff @(posedge clk or negedge nR) begin
    if (!nR) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_tag_q   <= '0;
      res_err_q   <= 1'b0;
      new_key_q   <= 1'b0;
      new_data_q  <= 1'b0;
      read_data_q <= 1'b0;
      enc_dec_q   <= 1'b0;
      key_q       <= '0;
      plain_q     <= '0;
      key_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_tag_q   <= res_tag_d;
      res_err_q   <= res_err_d;
      new_key_q   <= new_key_d;
      new_data_q  <= new_data_d;
      read_data_q <= read_data_d;
      enc_dec_q   <= enc_dec_d;
      key_q       <= key_d;
      plain_q     <= plain_d;
      key_valid_q <= key_valid_d;
    end
  end

  assign req_ready     = req_ready_q;
  assign res_valid     = res_valid_q;
  assign res_data      = res_data_q;
  assign res_tag       = res_tag_q;
  assign res_err       = res_err_q;
  assign core_newKey   = new_key_q;
  assign core_newData  = new_data_q;
  assign core_readData = read_data_q;
  assign core_enc_dec  = enc_dec_q;
  assign core_key      = key_q;
  assign core_plain    = plain_q;

endmodule

// File: tb/tb_simon_job_ctrl.sv
// Randomized bench for simon_job_ctrl with a behavioural SIMON 64/96 core and job model.
module tb_simon_job_ctrl;
  import simon_pkg::*;

  localparam int unsigned TO = 16;
  localparam logic [95:0] KAT_KEY = 96'h131211100B0A090803020100;
  localparam logic [63:0] KAT_PT  = 64'h6F7220676E696C63;
  localparam logic [63:0] KAT_CT  = 64'h5CA2E27F111A8FC8;
  localparam logic [61:0] Z2      = 62'b10101111011100000011010010011000101000010001111110010110110011;

  logic        clk = 1'b0;
  logic        nR;
  logic        req_valid, req_ready, req_enc_dec;
  logic [63:0] req_data;
  logic [95:0] req_key;
  logic [3:0]  req_tag;
  logic        res_valid, res_ready, res_err;
  logic [63:0] res_data;
  logic [3:0]  res_tag;
  logic        core_newKey, core_newData, core_readData, core_enc_dec;
  logic [95:0] core_key;
  logic [63:0] core_plain;
  logic        core_ldKey, core_ldData, core_doneKey, core_doneData;
  logic [63:0] core_cipher;
  logic [234:0] all_outs;

  always #5 clk = ~clk;

  simon_job_ctrl #(.N(32), .M(3), .TAGW(4), .TIMEOUT(TO)) dut (
    .clk(clk), .nR(nR),
    .req_valid(req_valid), .req_ready(req_ready), .req_enc_dec(req_enc_dec),
    .req_data(req_data), .req_key(req_key), .req_tag(req_tag),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_tag(res_tag), .res_err(res_err),
    .core_newKey(core_newKey), .core_newData(core_newData),
    .core_readData(core_readData), .core_enc_dec(core_enc_dec),
    .core_key(core_key), .core_plain(core_plain),
    .core_ldKey(core_ldKey), .core_ldData(core_ldData),
    .core_doneKey(core_doneKey), .core_doneData(core_doneData),
    .core_cipher(core_cipher)
  );

  assign all_outs = {req_ready, res_valid, res_data, res_tag, res_err, core_newKey,
                     core_newData, core_readData, core_enc_dec, core_key, core_plain};

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference SIMON 64/96 computed straight from the cipher definition.
  function automatic logic [31:0] rol(input logic [31:0] x, input int s);
    return (x << s) | (x >> (32 - s));
  endfunction

  function automatic logic [31:0] ror(input logic [31:0] x, input int s);
    return (x >> s) | (x << (32 - s));
  endfunction

  function automatic logic [31:0] rf(input logic [31:0] x);
    return (rol(x, 1) & rol(x, 8)) ^ rol(x, 2);
  endfunction

  function automatic logic [63:0] simon(input bit enc, input logic [95:0] key, input logic [63:0] blk);
    key_t        kw;
    logic [31:0] rk [0:41];
    logic [31:0] x, y, t;
    logic [61:0] z;
    z  = Z2;
    kw = key;
    for (int i = 0; i < 3; i++) rk[i] = kw[i];
    for (int i = 3; i < 42; i++) begin
      t = ror(rk[i-1], 3);
      t = t ^ ror(t, 1);
      rk[i] = ~rk[i-3] ^ t ^ {31'd0, z[61-(i-3)]} ^ 32'd3;
    end
    x = blk[63:32];
    y = blk[31:0];
    if (enc) begin
      for (int i = 0; i < 42; i++) begin
        t = x; x = y ^ rf(x) ^ rk[i]; y = t;
      end
    end else begin
      for (int i = 41; i >= 0; i--) begin
        t = y; y = x ^ rf(y) ^ rk[i]; x = t;
      end
    end
    return {x, y};
  endfunction

  // Behavioural core: random handshake latencies; cmode 1 never loads data, cmode 2 is slow.
  int          cmode = 0;
  int          kst = 0, dst = 0, kd = 0, dd = 0;
  logic [95:0] m_key;
  logic [63:0] cres;

  initial begin
    core_ldKey = 0; core_doneKey = 0; core_ldData = 0; core_doneData = 0;
    core_cipher = '0; m_key = '0; cres = '0;
    forever begin
      @(posedge clk); #1;
      core_ldKey = 0; core_doneKey = 0; core_ldData = 0;
      if (!nR) begin
        core_doneData = 0; kst = 0; dst = 0;
      end else begin
        if (kst == 0 && core_newKey) begin kst = 1; kd = int'($urandom_range(0, 2)); end
        if (kst == 1) begin
          if (!core_newKey) kst = 0;
          else if (kd == 0) begin
            core_ldKey = 1; m_key = core_key;
            if ($urandom_range(0, 3) == 0) begin core_doneKey = 1; kst = 0; end
            else begin kst = 2; kd = int'($urandom_range(0, 3)); end
          end else kd--;
        end else if (kst == 2) begin
          if (kd == 0) begin core_doneKey = 1; kst = 0; end else kd--;
        end

        if (dst == 0 && core_newData) begin dst = 1; dd = int'($urandom_range(0, 2)); end
        if (dst == 1) begin
          if (!core_newData) dst = 0;
          else if (cmode != 1) begin
            if (dd == 0) begin
              core_ldData = 1;
              cres = simon(core_enc_dec, m_key, core_plain);
              core_cipher = {$urandom, $urandom};
              if (cmode == 0 && $urandom_range(0, 3) == 0) begin
                core_doneData = 1; core_cipher = cres; dst = 3; dd = int'($urandom_range(0, 2));
              end else begin
                dst = 2; dd = (cmode == 2) ? 8 : int'($urandom_range(0, 3));
              end
            end else dd--;
          end
        end else if (dst == 2) begin
          if (dd == 0) begin
            core_doneData = 1; core_cipher = cres; dst = 3; dd = int'($urandom_range(0, 2));
          end else dd--;
        end else if (dst == 3) begin
          if (core_readData) begin
            if (dd == 0) begin core_doneData = 0; core_cipher = {$urandom, $urandom}; dst = 0; end
            else dd--;
          end
        end
      end
    end
  end

  int   nk_rises = 0;
  int   nd_high = 0;
  logic nk_prev = 1'b0;

  always @(negedge clk) begin
    if (core_newKey && !nk_prev) nk_rises++;
    nk_prev = core_newKey;
    if (core_newData) nd_high++;
  end

  // Job-level model: the key the core should be holding.
  logic        mk_valid;
  logic [95:0] mk;

  task automatic run_job(input bit enc, input logic [95:0] key, input logic [63:0] data,
                         input logic [3:0] tag, input int hold, input bit exp_err,
                         input bit use_kat, input logic [63:0] kat);
    bit          exp_nk;
    logic [63:0] exp_d;
    int          n;
    int          nk0;
    exp_nk = !mk_valid || (key != mk);
    exp_d  = exp_err ? 64'd0 : (use_kat ? kat : simon(enc, key, data));
    req_enc_dec = enc; req_key = key; req_data = data; req_tag = tag; req_valid = 1;
    n = 0;
    while (!req_ready && n < 100) begin @(negedge clk); n++; end
    chk("req_ready_wait", 256'(n < 100), 256'(1));
    @(posedge clk); #1 req_valid = 0;
    nk0 = nk_rises;
    nd_high = 0;
    @(negedge clk);
    chk("newkey_after_accept", 256'(core_newKey), 256'(exp_nk));
    chk("newdata_after_accept", 256'(core_newData), 256'(!exp_nk));
    n = 0;
    while (!res_valid && n < 300) begin @(negedge clk); n++; end
    chk("res_valid_wait", 256'(n < 300), 256'(1));
    chk("res_data", 256'(res_data), 256'(exp_d));
    chk("res_tag", 256'(res_tag), 256'(tag));
    chk("res_err", 256'(res_err), 256'(exp_err));
    chk("newkey_pulses", 256'(nk_rises - nk0), 256'(exp_nk));
    if (exp_err) begin
      chk("abort_cycles", 256'(nd_high), 256'(TO));
      chk("abort_strobes", 256'({core_newKey, core_newData, core_readData}), 256'(0));
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_res", 256'({res_valid, res_data, res_tag, res_err}), 256'({1'b1, exp_d, tag, exp_err}));
      chk("hold_req_ready", 256'(req_ready), 256'(0));
      chk("hold_newdata", 256'(core_newData), 256'(0));
    end
    res_ready = 1;
    @(posedge clk); #1 res_ready = 0;
    @(negedge clk);
    chk("res_valid_clear", 256'(res_valid), 256'(0));
    chk("req_ready_idle", 256'(req_ready), 256'(1));
    if (exp_err) mk_valid = 0;
    else begin mk_valid = 1; mk = key; end
  endtask

  logic [95:0] pool [0:2];
  logic [95:0] rkey;
  int          n;

  initial begin
    nR = 0; req_valid = 0; req_enc_dec = 0; req_data = '0; req_key = '0; req_tag = '0;
    res_ready = 0; mk_valid = 0; mk = '0;
    pool[0] = KAT_KEY; pool[1] = 96'h0; pool[2] = {$urandom, $urandom, $urandom};
    repeat (3) @(negedge clk);
    chk("reset_outputs", 256'(all_outs), 256'(0));
    nR = 1;
    @(negedge clk);
    chk("req_ready_after_reset", 256'(req_ready), 256'(1));

    run_job(1, KAT_KEY, KAT_PT, 4'd3, 1, 0, 1, KAT_CT);
    run_job(0, KAT_KEY, KAT_CT, 4'd4, 0, 0, 1, KAT_PT);
    run_job(1, 96'h0, {$urandom, $urandom}, 4'd5, 0, 0, 0, 64'd0);
    run_job(0, 96'h0, {$urandom, $urandom}, 4'd6, 0, 0, 0, 64'd0);
    run_job(1, KAT_KEY, {$urandom, $urandom}, 4'd7, 20, 0, 0, 64'd0);

    for (int j = 0; j < 40; j++) begin
      rkey = pool[$urandom_range(0, 2)];
      run_job(1'($urandom_range(0, 1)), rkey, {$urandom, $urandom}, 4'($urandom),
              int'($urandom_range(0, 3)), 0, 0, 64'd0);
    end

    cmode = 1;
    run_job(1, KAT_KEY, KAT_PT, 4'd9, 2, 1, 0, 64'd0);
    cmode = 0;
    run_job(1, KAT_KEY, KAT_PT, 4'd10, 0, 0, 1, KAT_CT);

    // Reset while the core is computing.
    cmode = 2;
    req_enc_dec = 1; req_key = pool[2]; req_data = {$urandom, $urandom}; req_tag = 4'd11; req_valid = 1;
    n = 0;
    while (!req_ready && n < 100) begin @(negedge clk); n++; end
    @(posedge clk); #1 req_valid = 0;
    n = 0;
    while (!core_ldData && n < 100) begin @(negedge clk); n++; end
    chk("ld_data_wait", 256'(n < 100), 256'(1));
    repeat (2) @(negedge clk);
    chk("in_data_wait", 256'({core_newData, core_readData, res_valid}), 256'(0));
    #2 nR = 0;
    #1 chk("async_reset_outputs", 256'(all_outs), 256'(0));
    @(posedge clk); @(posedge clk); @(negedge clk);
    chk("reset_held_outputs", 256'(all_outs), 256'(0));
    nR = 1;
    mk_valid = 0;
    cmode = 0;
    run_job(1, KAT_KEY, KAT_PT, 4'd12, 1, 0, 1, KAT_CT);
    run_job(0, KAT_KEY, KAT_CT, 4'd13, 0, 0, 1, KAT_PT);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench time limit");
  end

endmodule
